// File: rtl/cacc_dbuf_rd_sched_if.sv
`default_nettype none
// ============================================================================
// cacc_dbuf_rd_sched_if : handshake bundle between CACC assembly, dbuf RAM and
//                         the delivery buffer.              Rev 1.0
// ============================================================================
interface cacc_dbuf_rd_sched_if #(
  parameter int DBUF_AWIDTH = 5
);
  logic                   op_en;
  logic                   wr_req;
  logic                   wr_layer_end;
  logic                   wr_ready;
  logic                   dbuf_wr_en;
  logic [DBUF_AWIDTH-1:0] dbuf_wr_addr;
  logic                   dbuf_rd_ready;
  logic                   dbuf_rd_en;
  logic [DBUF_AWIDTH-1:0] dbuf_rd_addr;
  logic                   dbuf_rd_layer_end;
  logic                   layer_done;
  logic [DBUF_AWIDTH:0]   dbuf_cnt;
  logic                   wr_ovf_err;

  modport slave (
    input  op_en, wr_req, wr_layer_end, dbuf_rd_ready,
    output wr_ready, dbuf_wr_en, dbuf_wr_addr, dbuf_rd_en, dbuf_rd_addr,
           dbuf_rd_layer_end, layer_done, dbuf_cnt, wr_ovf_err
  );

  modport master (
    output op_en, wr_req, wr_layer_end, dbuf_rd_ready,
    input  wr_ready, dbuf_wr_en, dbuf_wr_addr, dbuf_rd_en, dbuf_rd_addr,
           dbuf_rd_layer_end, layer_done, dbuf_cnt, wr_ovf_err
  );
endinterface
`default_nettype wire

// File: rtl/cacc_dbuf_rd_sched.sv
`default_nettype none
// ============================================================================
// cacc_dbuf_rd_sched : dbuf pointer/occupancy owner and read scheduler with
//                      layer-end tracking.                  Rev 1.0
// ============================================================================
module cacc_dbuf_rd_sched #(
  parameter int DBUF_DEPTH  = 32,
  parameter int DBUF_AWIDTH = 5
) (
  input  wire logic             nvdla_core_clk,
  input  wire logic             nvdla_core_rstn,
  cacc_dbuf_rd_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DBUF_AWIDTH:0] FULL_CNT = (DBUF_AWIDTH+1)'(DBUF_DEPTH);

  state_t                 state_q, state_d;
  logic [DBUF_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DBUF_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DBUF_AWIDTH:0]   cnt_q, cnt_d;
  logic [DBUF_DEPTH-1:0]  flag_q, flag_d;
  logic                   layer_done_q, layer_done_d;
  logic                   ovf_err_q, ovf_err_d;

  logic wr_ready;
  logic wr_acc;
  logic rd_en;
  logic rd_last;

  always_comb begin
    // Fullness looks at the registered count only; a same-cycle read frees nothing.
    wr_ready     = (state_q == ST_RUN) && (cnt_q != FULL_CNT);
    wr_acc       = bus.wr_req & wr_ready;
    rd_en        = (state_q != ST_IDLE) && (cnt_q != '0) && bus.dbuf_rd_ready;
    rd_last      = rd_en & flag_q[rd_ptr_q];

    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q + DBUF_AWIDTH'(wr_acc);
    rd_ptr_d     = rd_ptr_q + DBUF_AWIDTH'(rd_en);
    cnt_d        = cnt_q + (DBUF_AWIDTH+1)'(wr_acc) - (DBUF_AWIDTH+1)'(rd_en);
    flag_d       = flag_q;
    layer_done_d = rd_last;
    ovf_err_d    = ovf_err_q;

    if (wr_acc) begin
      flag_d[wr_ptr_q] = bus.wr_layer_end;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.op_en) begin
          state_d   = ST_RUN;
          ovf_err_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (wr_acc && bus.wr_layer_end) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any write that is not accepted is lost and remembered as an error.
    if (bus.wr_req && !wr_ready) begin
      ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      flag_q       <= '0;
      layer_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      layer_done_q <= layer_done_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign bus.wr_ready          = wr_ready;
  assign bus.dbuf_wr_en        = wr_acc;
  assign bus.dbuf_wr_addr      = wr_ptr_q;
  assign bus.dbuf_rd_en        = rd_en;
  assign bus.dbuf_rd_addr      = rd_ptr_q;
  assign bus.dbuf_rd_layer_end = rd_last;
  assign bus.layer_done        = layer_done_q;
  assign bus.dbuf_cnt          = cnt_q;
  assign bus.wr_ovf_err        = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cacc_dbuf_rd_sched.sv
`default_nettype none
// ============================================================================
// tb_cacc_dbuf_rd_sched : directed self-checking bench for cacc_dbuf_rd_sched.
//                                                           Rev 1.0
// ============================================================================
module tb_cacc_dbuf_rd_sched;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  cacc_dbuf_rd_sched_if #(.DBUF_AWIDTH(AW)) bus ();

  cacc_dbuf_rd_sched #(
    .DBUF_DEPTH  (DEPTH),
    .DBUF_AWIDTH (AW)
  ) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .bus             (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.op_en         = 1'b0;
    bus.wr_req        = 1'b0;
    bus.wr_layer_end  = 1'b0;
    bus.dbuf_rd_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic start_layer;
    bus.op_en = 1'b1;
    tick();
    bus.op_en = 1'b0;
  endtask

  // Writes n entries with reads held off; the last one optionally carries layer end.
  task automatic write_n(input int n, input int base, input bit last_end, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.wr_req       = 1'b1;
      bus.wr_layer_end = last_end && (i == n - 1);
      #1;
      check({tag, "_wr_addr"}, 32'(bus.dbuf_wr_addr), 32'((base + i) % DEPTH));
      tick();
    end
    bus.wr_req       = 1'b0;
    bus.wr_layer_end = 1'b0;
  endtask

  task automatic drain_n(input int n, input int base, input string tag);
    bus.dbuf_rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check({tag, "_rd_en"}, 32'(bus.dbuf_rd_en), 32'd1);
      check({tag, "_rd_addr"}, 32'(bus.dbuf_rd_addr), 32'((base + i) % DEPTH));
      check({tag, "_rd_last"}, 32'(bus.dbuf_rd_layer_end), (i == n - 1) ? 32'd1 : 32'd0);
      tick();
    end
    bus.dbuf_rd_ready = 1'b0;
    check({tag, "_layer_done"}, 32'(bus.layer_done), 32'd1);
    check({tag, "_cnt_empty"}, 32'(bus.dbuf_cnt), 32'd0);
    tick();
    check({tag, "_layer_done_pulse"}, 32'(bus.layer_done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn     = 1'b0;
    idle_inputs();
    #12;

    // Reset values
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_rd_en", 32'(bus.dbuf_rd_en), 32'd0);
    check("rst_cnt", 32'(bus.dbuf_cnt), 32'd0);
    check("rst_layer_done", 32'(bus.layer_done), 32'd0);
    check("rst_ovf", 32'(bus.wr_ovf_err), 32'd0);
    check("rst_wr_addr", 32'(bus.dbuf_wr_addr), 32'd0);
    check("rst_rd_addr", 32'(bus.dbuf_rd_addr), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Three-entry layer with reads always ready
    start_layer();
    check("t1_wr_ready", 32'(bus.wr_ready), 32'd1);
    bus.dbuf_rd_ready = 1'b1;
    bus.wr_req        = 1'b1;
    #1;
    check("t1_wr0_en", 32'(bus.dbuf_wr_en), 32'd1);
    check("t1_wr0_addr", 32'(bus.dbuf_wr_addr), 32'd0);
    check("t1_rd_en_empty", 32'(bus.dbuf_rd_en), 32'd0);
    tick();
    #1;
    check("t1_wr1_addr", 32'(bus.dbuf_wr_addr), 32'd1);
    check("t1_rd0_en", 32'(bus.dbuf_rd_en), 32'd1);
    check("t1_rd0_addr", 32'(bus.dbuf_rd_addr), 32'd0);
    check("t1_rd0_last", 32'(bus.dbuf_rd_layer_end), 32'd0);
    tick();
    bus.wr_layer_end = 1'b1;
    #1;
    check("t1_wr2_addr", 32'(bus.dbuf_wr_addr), 32'd2);
    check("t1_rd1_addr", 32'(bus.dbuf_rd_addr), 32'd1);
    check("t1_rd1_last", 32'(bus.dbuf_rd_layer_end), 32'd0);
    tick();
    bus.wr_req       = 1'b0;
    bus.wr_layer_end = 1'b0;
    #1;
    check("t1_drain_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t1_rd2_addr", 32'(bus.dbuf_rd_addr), 32'd2);
    check("t1_rd2_last", 32'(bus.dbuf_rd_layer_end), 32'd1);
    check("t1_ld_before", 32'(bus.layer_done), 32'd0);
    tick();
    check("t1_layer_done", 32'(bus.layer_done), 32'd1);
    check("t1_cnt", 32'(bus.dbuf_cnt), 32'd0);
    check("t1_rd_en_idle", 32'(bus.dbuf_rd_en), 32'd0);
    bus.dbuf_rd_ready = 1'b0;
    tick();
    check("t1_layer_done_off", 32'(bus.layer_done), 32'd0);
    check("t1_idle_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("t1_ovf_clean", 32'(bus.wr_ovf_err), 32'd0);

    // Fill to full, then overflow, then simultaneous write and read on full
    do_reset();
    start_layer();
    write_n(DEPTH, 0, 1'b0, "t2");
    check("t2_cnt_full", 32'(bus.dbuf_cnt), 32'd32);
    check("t2_wr_ready_full", 32'(bus.wr_ready), 32'd0);
    bus.wr_req = 1'b1;
    #1;
    check("t2_ovf_wr_en", 32'(bus.dbuf_wr_en), 32'd0);
    tick();
    check("t2_ovf_err", 32'(bus.wr_ovf_err), 32'd1);
    check("t2_cnt_hold", 32'(bus.dbuf_cnt), 32'd32);
    check("t2_wr_ptr_hold", 32'(bus.dbuf_wr_addr), 32'd0);
    bus.dbuf_rd_ready = 1'b1;
    #1;
    check("t3_rd_en", 32'(bus.dbuf_rd_en), 32'd1);
    check("t3_rd_addr", 32'(bus.dbuf_rd_addr), 32'd0);
    check("t3_wr_en", 32'(bus.dbuf_wr_en), 32'd0);
    tick();
    bus.wr_req        = 1'b0;
    bus.dbuf_rd_ready = 1'b0;
    check("t3_cnt", 32'(bus.dbuf_cnt), 32'd31);
    check("t3_wr_ready", 32'(bus.wr_ready), 32'd1);

    // Two consecutive 20-entry layers; second wraps the pointers
    do_reset();
    start_layer();
    write_n(20, 0, 1'b1, "t4a");
    check("t4a_drain_wr_ready", 32'(bus.wr_ready), 32'd0);
    drain_n(20, 0, "t4a");
    start_layer();
    write_n(20, 20, 1'b1, "t4b");
    check("t4b_cnt", 32'(bus.dbuf_cnt), 32'd20);
    drain_n(20, 20, "t4b");
    check("t4_ovf_clean", 32'(bus.wr_ovf_err), 32'd0);

    // Read pacing by a toggling ready
    do_reset();
    start_layer();
    write_n(4, 0, 1'b0, "t5");
    check("t5_cnt4", 32'(bus.dbuf_cnt), 32'd4);
    bus.dbuf_rd_ready = 1'b1;
    #1;
    check("t5_c0_en", 32'(bus.dbuf_rd_en), 32'd1);
    check("t5_c0_addr", 32'(bus.dbuf_rd_addr), 32'd0);
    tick();
    bus.dbuf_rd_ready = 1'b0;
    #1;
    check("t5_c1_en", 32'(bus.dbuf_rd_en), 32'd0);
    check("t5_c1_cnt", 32'(bus.dbuf_cnt), 32'd3);
    tick();
    bus.dbuf_rd_ready = 1'b1;
    #1;
    check("t5_c2_cnt", 32'(bus.dbuf_cnt), 32'd3);
    check("t5_c2_en", 32'(bus.dbuf_rd_en), 32'd1);
    check("t5_c2_addr", 32'(bus.dbuf_rd_addr), 32'd1);
    tick();
    bus.dbuf_rd_ready = 1'b0;
    #1;
    check("t5_c3_en", 32'(bus.dbuf_rd_en), 32'd0);
    check("t5_c3_addr", 32'(bus.dbuf_rd_addr), 32'd2);
    check("t5_c3_cnt", 32'(bus.dbuf_cnt), 32'd2);
    tick();

    // Asynchronous reset in the middle of a layer
    do_reset();
    start_layer();
    write_n(5, 0, 1'b0, "t6");
    check("t6_cnt5", 32'(bus.dbuf_cnt), 32'd5);
    bus.dbuf_rd_ready = 1'b1;
    #1;
    check("t6_rd_en_pre", 32'(bus.dbuf_rd_en), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_rd_en_rst", 32'(bus.dbuf_rd_en), 32'd0);
    check("t6_cnt_rst", 32'(bus.dbuf_cnt), 32'd0);
    check("t6_wr_addr_rst", 32'(bus.dbuf_wr_addr), 32'd0);
    bus.dbuf_rd_ready = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start_layer();
    bus.wr_req = 1'b1;
    #1;
    check("t6_restart_wr_en", 32'(bus.dbuf_wr_en), 32'd1);
    check("t6_restart_addr", 32'(bus.dbuf_wr_addr), 32'd0);
    tick();
    bus.wr_req = 1'b0;
    check("t6_restart_cnt", 32'(bus.dbuf_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire

// File: doc/cacc_dbuf_rd_sched.md
Name: cacc_dbuf_rd_sched

Overview:
Sequences the CACC delivery buffer.
- Owns the write and read pointers of the dbuf RAM and tracks its occupancy.
- Issues one read per committed entry whenever the delivery stage reports ready.
- Marks the read that carries the layer end, and pulses layer-done back to the CACC control path.
- Sits between the assembly stage (write side) and the delivery buffer (read side).

Parameters:
DBUF_DEPTH, 32, number of dbuf entries (power of two)
DBUF_AWIDTH, 5, log2(DBUF_DEPTH)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  asynchronous active-low reset
op_en  in  1  layer start pulse from register block
wr_req  in  1  assembly stage commits one dbuf entry
wr_layer_end  in  1  qualifies wr_req: this entry is the last of the layer
wr_ready  out  1  write accepted this cycle if wr_req
dbuf_wr_en  out  1  RAM write enable
dbuf_wr_addr  out  DBUF_AWIDTH  RAM write address
dbuf_rd_ready  in  1  delivery buffer can take a read
dbuf_rd_en  out  1  read request to delivery buffer
dbuf_rd_addr  out  DBUF_AWIDTH  read address
dbuf_rd_layer_end  out  1  qualifies dbuf_rd_en: last read of layer
layer_done  out  1  one-cycle pulse, registered
dbuf_cnt  out  DBUF_AWIDTH+1  current occupancy
wr_ovf_err  out  1  sticky: wr_req seen while full or while not RUN

Behaviour:
Interface:
- One clock, nvdla_core_clk.
- Reset nvdla_core_rstn is asynchronous and active-low.
- All state is reset to 0: pointers, count, flags, FSM=IDLE, layer_done, wr_ovf_err.
- Consequently every output is 0 during reset; wr_ready is 0 in IDLE.

FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on op_en. Entering RUN clears wr_ovf_err. op_en in RUN or DRAIN is ignored.
- RUN -> DRAIN on an accepted write with wr_layer_end=1.
- DRAIN -> IDLE on the cycle the read with dbuf_rd_layer_end=1 is issued.
- layer_done is registered, so it is high exactly one cycle after that read.

Write side:
- wr_ready = (state==RUN) & (dbuf_cnt != DBUF_DEPTH). Fullness uses the current count only; a simultaneous read does not free a slot that same cycle.
- Accepted write = wr_req & wr_ready:
  - dbuf_wr_en = 1 combinationally;
  - dbuf_wr_addr = wr_ptr;
  - flag[wr_ptr] <= wr_layer_end;
  - wr_ptr increments mod DBUF_DEPTH.
- wr_req & ~wr_ready sets wr_ovf_err. The write is dropped and no pointer moves.
- wr_req in DRAIN or IDLE is dropped and sets wr_ovf_err.

Read side:
- dbuf_rd_en = (state!=IDLE) & (dbuf_cnt!=0) & dbuf_rd_ready, combinational.
- dbuf_rd_addr = rd_ptr.
- dbuf_rd_layer_end = dbuf_rd_en & flag[rd_ptr].
- On dbuf_rd_en, rd_ptr increments mod DBUF_DEPTH.
- Successive reads are paced only by dbuf_rd_ready. The block inserts no bubble of its own.

Count and pointers:
- dbuf_cnt_next = dbuf_cnt + wr_acc - dbuf_rd_en. A simultaneous write and read leaves the count unchanged.
- Pointers wrap naturally at DBUF_DEPTH. Full is distinguished from empty by dbuf_cnt, not by pointer equality.
- Pointers are NOT reset between layers; the next layer continues from the current positions.
- At DRAIN -> IDLE, dbuf_cnt is 0 by construction. If it is not, that is a protocol error; the FSM still returns to IDLE.

Reset mid-operation:
- Asynchronous: pointers, flags and FSM clear immediately.
- Outputs are 0 while reset is asserted.
- Data already in the RAM is abandoned.

Test Plan:
- Reset, op_en, 3 writes (last with wr_layer_end), dbuf_rd_ready held 1 -> reads at addr 0,1,2; dbuf_rd_layer_end only on addr 2; layer_done high one cycle later; FSM back in IDLE.
- dbuf_rd_ready=0, 32 writes -> dbuf_cnt=32, wr_ready=0; a 33rd wr_req sets wr_ovf_err, dbuf_wr_en stays 0, count stays 32.
- Full buffer, simultaneous wr_req and dbuf_rd_ready=1 -> read issued at addr 0, write rejected; next cycle count=31, wr_ready=1.
- Two consecutive layers of 20 entries each -> second layer writes 20..31 then 0..7 (wrap); reads follow the same order; two layer_done pulses.
- dbuf_rd_ready toggled 1,0,1,0 with count=4 -> dbuf_rd_en only in ready cycles; rd_ptr advances 0->1->2; count decrements only on those cycles.
- Reset asserted mid-layer with count=5 -> dbuf_rd_en=0 and dbuf_cnt=0 immediately; after release, op_en restarts writes at addr 0.
